// File: rtl/day10_pkg.sv
// rtl/day10_pkg.sv - ASCII tokens and parser state encoding for the day10 line parser.
package day10_pkg;

    localparam logic [7:0] CH_LBRACK = 8'h5B;
    localparam logic [7:0] CH_RBRACK = 8'h5D;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_LPAREN = 8'h28;
    localparam logic [7:0] CH_RPAREN = 8'h29;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_NL     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [7:0] CH_ZERO   = 8'h30;
    localparam logic [7:0] CH_NINE   = 8'h39;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE_START,
        S_LIGHTS,
        S_SEP,
        S_BTN_NUM,
        S_SKIP,
        S_HOLD,
        S_ERROR
    } parse_state_t;

endpackage

// File: rtl/axi_stream_if.sv
// rtl/axi_stream_if.sv - Byte stream with tdata/tvalid/tready/tlast handshake.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/day10_input_if.sv
// rtl/day10_input_if.sv - One parsed machine record: lights, target pattern and button masks.
interface day10_input_if #(
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 16,
    parameter int MAX_NUM_LIGHTS_W  = ($clog2(MAX_NUM_LIGHTS + 1) < 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = ($clog2(MAX_NUM_BUTTONS + 1) < 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1)
);
    logic [MAX_NUM_LIGHTS_W-1:0]                   num_lights;
    logic [MAX_NUM_BUTTONS_W-1:0]                  num_buttons;
    logic [MAX_NUM_LIGHTS-1:0]                     target_lights_arrangement;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] buttons;

    modport producer (output num_lights, output num_buttons,
                      output target_lights_arrangement, output buttons);
    modport consumer (input num_lights, input num_buttons,
                      input target_lights_arrangement, input buttons);
endinterface

// File: rtl/ascii_decimal_accum.sv
// rtl/ascii_decimal_accum.sv - Decimal digit accumulator, saturating at 31, with digit-seen flag.
module ascii_decimal_accum (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_digit_strobe,
    input  logic [3:0] i_digit,
    output logic [4:0] o_value,
    output logic       o_digit_seen
);
    logic [4:0] r_value;
    logic       r_digit_seen;
    logic [8:0] w_next;

    // 31*10+9 fits in 9 bits, so the saturation compare sees the true value
    assign w_next = ({4'd0, r_value} * 9'd10) + {5'd0, i_digit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value      <= 5'd0;
            r_digit_seen <= 1'b0;
        end else if (i_clear) begin
            r_value      <= 5'd0;
            r_digit_seen <= 1'b0;
        end else if (i_digit_strobe) begin
            r_value      <= (w_next > 9'd31) ? 5'd31 : w_next[4:0];
            r_digit_seen <= 1'b1;
        end
    end

    assign o_value      = r_value;
    assign o_digit_seen = r_digit_seen;
endmodule

// File: rtl/day10_line_parser.sv
// rtl/day10_line_parser.sv - Parses one ASCII machine line per record into day10_input_if,
// holding the record until the consumer accepts it.
module day10_line_parser #(
    parameter int MAX_NUM_LIGHTS    = 10,
    parameter int MAX_NUM_BUTTONS   = 16,
    parameter int MAX_NUM_LIGHTS_W  = ($clog2(MAX_NUM_LIGHTS + 1) < 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1),
    parameter int MAX_NUM_BUTTONS_W = ($clog2(MAX_NUM_BUTTONS + 1) < 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
    parameter int AXI_DATA_WIDTH    = 8
) (
    input  logic            clk,
    input  logic            rst,
    axi_stream_if.slave     data_in,
    day10_input_if.producer day10_input,
    output logic            valid,
    input  logic            accepted,
    output logic            last,
    output logic            error
);
    import day10_pkg::*;

    localparam logic [MAX_NUM_LIGHTS_W-1:0]  LIGHTS_FULL  = MAX_NUM_LIGHTS_W'(MAX_NUM_LIGHTS);
    localparam logic [MAX_NUM_BUTTONS_W-1:0] BUTTONS_FULL = MAX_NUM_BUTTONS_W'(MAX_NUM_BUTTONS);

    parse_state_t                                  r_state;
    logic                                          r_tready;
    logic                                          r_valid;
    logic                                          r_last;
    logic                                          r_error;
    logic [MAX_NUM_LIGHTS_W-1:0]                   r_num_lights;
    logic [MAX_NUM_BUTTONS_W-1:0]                  r_num_buttons;
    logic [MAX_NUM_LIGHTS-1:0]                     r_target;
    logic [MAX_NUM_BUTTONS-1:0][MAX_NUM_LIGHTS-1:0] r_buttons;

    logic [AXI_DATA_WIDTH-1:0] w_byte;
    logic                      w_beat;
    logic                      w_is_ws;
    logic                      w_is_digit;
    logic                      w_is_sep;
    logic [4:0]                w_idx;
    logic                      w_idx_seen;
    logic                      w_idx_ok;
    logic                      w_acc_clear;
    logic                      w_acc_strobe;
    logic [MAX_NUM_LIGHTS-1:0] w_light_mask;
    logic [MAX_NUM_LIGHTS-1:0] w_idx_mask;
    logic                      w_fault;

    assign w_byte       = data_in.tdata;
    assign w_beat       = data_in.tvalid && r_tready;
    assign w_is_ws      = (w_byte == CH_SP) || (w_byte == CH_CR);
    assign w_is_digit   = (w_byte >= CH_ZERO) && (w_byte <= CH_NINE);
    assign w_is_sep     = (w_byte == CH_COMMA) || (w_byte == CH_RPAREN);
    assign w_idx_ok     = w_idx_seen && (32'(w_idx) < 32'(r_num_lights));
    assign w_light_mask = MAX_NUM_LIGHTS'(1) << r_num_lights;
    assign w_idx_mask   = MAX_NUM_LIGHTS'(1) << w_idx;
    assign w_acc_clear  = w_beat && (((r_state == S_SEP) && (w_byte == CH_LPAREN)) ||
                                     ((r_state == S_BTN_NUM) && (w_byte == CH_COMMA)));
    assign w_acc_strobe = w_beat && (r_state == S_BTN_NUM) && w_is_digit;

    ascii_decimal_accum u_idx_accum (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (w_acc_clear),
        .i_digit_strobe (w_acc_strobe),
        .i_digit        (w_byte[3:0]),
        .o_value        (w_idx),
        .o_digit_seen   (w_idx_seen)
    );

    // Malformed-beat detection for the parse states; only meaningful when w_beat is high
    always_comb begin
        w_fault = 1'b0;
        if (data_in.tlast && (r_state != S_SKIP) && (r_state != S_LINE_START))
            w_fault = 1'b1;
        case (r_state)
            S_LINE_START: if (!(w_is_ws || w_byte == CH_NL || w_byte == CH_LBRACK)) w_fault = 1'b1;
            S_LIGHTS: begin
                if (w_byte == CH_DOT || w_byte == CH_HASH) begin
                    if (r_num_lights == LIGHTS_FULL) w_fault = 1'b1;
                end else if (w_byte == CH_RBRACK) begin
                    if (r_num_lights == '0) w_fault = 1'b1;
                end else begin
                    w_fault = 1'b1;
                end
            end
            S_SEP: begin
                if (w_byte == CH_LPAREN) begin
                    if (r_num_buttons == BUTTONS_FULL) w_fault = 1'b1;
                end else if (!(w_is_ws || w_byte == CH_LBRACE)) begin
                    w_fault = 1'b1;
                end
            end
            S_BTN_NUM: begin
                if (w_is_sep) begin
                    if (!w_idx_ok) w_fault = 1'b1;
                end else if (!w_is_digit) begin
                    w_fault = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tready      <= 1'b0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_error       <= 1'b0;
            r_num_lights  <= '0;
            r_num_buttons <= '0;
            r_target      <= '0;
            r_buttons     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tready <= 1'b1;
                    r_state  <= S_LINE_START;
                end
                S_HOLD: begin
                    if (accepted) begin
                        r_valid  <= 1'b0;
                        r_last   <= 1'b0;
                        r_tready <= 1'b1;
                        r_state  <= S_LINE_START;
                    end
                end
                S_ERROR: r_error <= 1'b1;
                default: begin
                    if (w_beat) begin
                        if (w_fault) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            case (r_state)
                                S_LINE_START: begin
                                    if (w_byte == CH_LBRACK) begin
                                        r_num_lights  <= '0;
                                        r_num_buttons <= '0;
                                        r_target      <= '0;
                                        r_buttons     <= '0;
                                        r_state       <= S_LIGHTS;
                                    end
                                end
                                S_LIGHTS: begin
                                    if (w_byte == CH_RBRACK) begin
                                        r_state <= S_SEP;
                                    end else begin
                                        if (w_byte == CH_HASH) r_target <= r_target | w_light_mask;
                                        r_num_lights <= r_num_lights + MAX_NUM_LIGHTS_W'(1);
                                    end
                                end
                                S_SEP: begin
                                    if (w_byte == CH_LPAREN)      r_state <= S_BTN_NUM;
                                    else if (w_byte == CH_LBRACE) r_state <= S_SKIP;
                                end
                                S_BTN_NUM: begin
                                    if (w_is_sep) begin
                                        for (int b = 0; b < MAX_NUM_BUTTONS; b++) begin
                                            if (r_num_buttons == MAX_NUM_BUTTONS_W'(b))
                                                r_buttons[b] <= r_buttons[b] | w_idx_mask;
                                        end
                                        if (w_byte == CH_RPAREN) begin
                                            r_num_buttons <= r_num_buttons + MAX_NUM_BUTTONS_W'(1);
                                            r_state       <= S_SEP;
                                        end
                                    end
                                end
                                S_SKIP: begin
                                    if (w_byte == CH_NL || data_in.tlast) begin
                                        r_valid  <= 1'b1;
                                        r_last   <= data_in.tlast;
                                        r_tready <= 1'b0;
                                        r_state  <= S_HOLD;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign data_in.tready                        = r_tready;
    assign valid                                 = r_valid;
    assign last                                  = r_last;
    assign error                                 = r_error;
    assign day10_input.num_lights                = r_num_lights;
    assign day10_input.num_buttons               = r_num_buttons;
    assign day10_input.target_lights_arrangement = r_target;
    assign day10_input.buttons                   = r_buttons;
endmodule

// File: tb/tb_day10_line_parser.sv
// tb/tb_day10_line_parser.sv - Directed self-checking bench for day10_line_parser.
module tb_day10_line_parser;
    localparam int L = 10;
    localparam int B = 16;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic accepted = 1'b0;
    logic valid;
    logic last;
    logic error;

    int n_tests = 0;
    int n_fail  = 0;

    axi_stream_if #(.DATA_WIDTH(8)) s_if ();
    day10_input_if #(.MAX_NUM_LIGHTS(L), .MAX_NUM_BUTTONS(B)) d_if ();

    day10_line_parser #(.MAX_NUM_LIGHTS(L), .MAX_NUM_BUTTONS(B)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (s_if),
        .day10_input (d_if),
        .valid       (valid),
        .accepted    (accepted),
        .last        (last),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is consumed.
    task automatic send_byte(input logic [7:0] b, input logic l);
        int n;
        n = 0;
        s_if.tdata  = b;
        s_if.tvalid = 1'b1;
        s_if.tlast  = l;
        while (!s_if.tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("tready_wait", 64'(s_if.tready), 64'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last_on_end);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_on_end && (i == s.len() - 1));
    endtask

    task automatic accept_rec();
        accepted = 1'b1;
        check("accept_cycle_tready", 64'(s_if.tready), 64'd0);
        @(negedge clk);
        accepted = 1'b0;
        check("accept_valid_drop", 64'(valid), 64'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        s_if.tdata  = 8'h00;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_tready", 64'(s_if.tready), 64'd0);
        check("rst_num_lights", 64'(d_if.num_lights), 64'd0);
        check("rst_buttons", 64'(d_if.buttons[0]), 64'd0);
        rst = 1'b0;
        check("idle_tready", 64'(s_if.tready), 64'd0);
        @(negedge clk);
        check("line_start_tready", 64'(s_if.tready), 64'd1);

        send_str("[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n", 1'b0);
        check("l1_valid", 64'(valid), 64'd1);
        check("l1_num_lights", 64'(d_if.num_lights), 64'd4);
        check("l1_target", 64'(d_if.target_lights_arrangement), 64'h6);
        check("l1_num_buttons", 64'(d_if.num_buttons), 64'd6);
        check("l1_btn0", 64'(d_if.buttons[0]), 64'h8);
        check("l1_btn1", 64'(d_if.buttons[1]), 64'hA);
        check("l1_btn2", 64'(d_if.buttons[2]), 64'h4);
        check("l1_btn3", 64'(d_if.buttons[3]), 64'hC);
        check("l1_btn4", 64'(d_if.buttons[4]), 64'h5);
        check("l1_btn5", 64'(d_if.buttons[5]), 64'h3);
        check("l1_btn6_unused", 64'(d_if.buttons[6]), 64'h0);
        check("l1_last", 64'(last), 64'd0);
        check("l1_error", 64'(error), 64'd0);

        s_if.tdata  = 8'h5B;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_tready", 64'(s_if.tready), 64'd0);
            check("hold_valid", 64'(valid), 64'd1);
            check("hold_btn5", 64'(d_if.buttons[5]), 64'h3);
        end
        s_if.tvalid = 1'b0;
        accept_rec();

        send_str("[#...#] (0,4) (1) {5}\n", 1'b0);
        check("l2_valid", 64'(valid), 64'd1);
        check("l2_num_lights", 64'(d_if.num_lights), 64'd5);
        check("l2_target", 64'(d_if.target_lights_arrangement), 64'h11);
        check("l2_num_buttons", 64'(d_if.num_buttons), 64'd2);
        check("l2_btn0", 64'(d_if.buttons[0]), 64'h11);
        check("l2_btn1", 64'(d_if.buttons[1]), 64'h2);
        check("l2_btn2_cleared", 64'(d_if.buttons[2]), 64'h0);
        accept_rec();

        send_str("\n\n[#] {1}", 1'b1);
        check("l3_valid", 64'(valid), 64'd1);
        check("l3_num_lights", 64'(d_if.num_lights), 64'd1);
        check("l3_target", 64'(d_if.target_lights_arrangement), 64'h1);
        check("l3_num_buttons", 64'(d_if.num_buttons), 64'd0);
        check("l3_btn0_cleared", 64'(d_if.buttons[0]), 64'h0);
        check("l3_last", 64'(last), 64'd1);
        accept_rec();

        send_str("[##########] (9,0) {1}\n", 1'b0);
        check("l4_valid", 64'(valid), 64'd1);
        check("l4_num_lights", 64'(d_if.num_lights), 64'd10);
        check("l4_target", 64'(d_if.target_lights_arrangement), 64'h3FF);
        check("l4_btn0", 64'(d_if.buttons[0]), 64'h201);
        check("l4_last", 64'(last), 64'd0);
        accept_rec();

        send_str("[##########] (9,10)", 1'b0);
        check("e1_error", 64'(error), 64'd1);
        check("e1_valid", 64'(valid), 64'd0);
        send_str("xy\n", 1'b1);
        check("e1_drain_tready", 64'(s_if.tready), 64'd1);
        check("e1_error_sticky", 64'(error), 64'd1);
        check("e1_valid_after", 64'(valid), 64'd0);
        reset_dut();
        check("e1_error_cleared", 64'(error), 64'd0);

        send_str("[..] (2)\n", 1'b0);
        check("e2_error", 64'(error), 64'd1);
        send_str("[#] {0}\n", 1'b0);
        check("e2_valid_never", 64'(valid), 64'd0);
        check("e2_error_sticky", 64'(error), 64'd1);
        reset_dut();

        send_str("[###########", 1'b0);
        check("e3_light_overflow", 64'(error), 64'd1);
        reset_dut();

        send_str("[#.#] (0,2", 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(valid), 64'd0);
        check("mid_rst_error", 64'(error), 64'd0);
        check("mid_rst_tready", 64'(s_if.tready), 64'd0);
        check("mid_rst_num_lights", 64'(d_if.num_lights), 64'd0);
        check("mid_rst_target", 64'(d_if.target_lights_arrangement), 64'h0);
        check("mid_rst_btn0", 64'(d_if.buttons[0]), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_str("[.#] (1) {0}\n", 1'b0);
        check("l5_valid", 64'(valid), 64'd1);
        check("l5_num_lights", 64'(d_if.num_lights), 64'd2);
        check("l5_target", 64'(d_if.target_lights_arrangement), 64'h2);
        check("l5_num_buttons", 64'(d_if.num_buttons), 64'd1);
        check("l5_btn0", 64'(d_if.buttons[0]), 64'h2);
        check("l5_btn1", 64'(d_if.buttons[1]), 64'h0);
        check("l5_error", 64'(error), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
